// File: rtl/servo_ramp.sv
// ----------------------------------------------------------------------------
// servo_ramp
//
// Slew-rate limiter placed directly in front of the servo PWM generator.
// A target position arrives over a valid/ready handshake. The output
// position then moves toward it by at most STEP codes per PWM frame.
// Position updates happen only on the frame-boundary tick, so the generator
// never sees its pulse width change in the middle of a pulse.
//
// The block keeps its own frame counter. That counter runs in lockstep with
// the generator's counter because both share the clock, reset, enable and
// period.
//
// Parameters
//   TCLK    clock period in ns (must match the generator)
//   TDUT    PWM frame period in ns (must match the generator); NDUT = TDUT/TCLK
//   DATA_W  position width
//   STEP    maximum position change per frame, 1 .. 2**DATA_W-1
//   INIT    position loaded at reset
//   POS_MIN / POS_MAX  target clamp bounds (present only with the macro below)
//
// Ports
//   clk        clock
//   rst_       asynchronous active-low reset
//   ena        frame-counter enable (same signal the generator receives)
//   tgt        target position
//   tgt_valid  tgt is valid
//   tgt_ready  block can accept a target (combinational from state and rst_)
//   pos        current position, feeds the generator's pos input
//   busy       ramp in progress
//   done       one-cycle pulse when pos reaches the target
//
// Configuration
//   SERVO_RAMP_LIMIT_EN  when defined, an accepted target is clamped to
//                        [POS_MIN, POS_MAX]; INIT must lie inside that range.
//                        When undefined, the target is used unchanged.
// ----------------------------------------------------------------------------
module servo_ramp #(
    parameter int TCLK    = 20,
    parameter int TDUT    = 20_000_000,
    parameter int DATA_W  = 8,
    parameter int STEP    = 4,
    parameter int INIT    = 2 ** (DATA_W - 1)
`ifdef SERVO_RAMP_LIMIT_EN
    ,
    parameter int POS_MIN = 0,
    parameter int POS_MAX = 2 ** DATA_W - 1
`endif
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              ena,
    input  logic [DATA_W-1:0] tgt,
    input  logic              tgt_valid,
    output logic              tgt_ready,
    output logic [DATA_W-1:0] pos,
    output logic              busy,
    output logic              done
);

    localparam int NDUT  = TDUT / TCLK;
    localparam int CNT_W = (NDUT > 1) ? $clog2(NDUT) : 1;

    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(NDUT - 1);
    localparam logic [DATA_W-1:0]        INIT_W   = DATA_W'(INIT);
    localparam logic [DATA_W-1:0]        STEP_W   = DATA_W'(STEP);
    // One extra bit keeps +/-STEP representable for any legal STEP.
    localparam logic signed [DATA_W:0]   STEP_S   = (DATA_W + 1)'(STEP);

`ifdef SERVO_RAMP_LIMIT_EN
    localparam logic [DATA_W-1:0] MIN_W = DATA_W'(POS_MIN);
    localparam logic [DATA_W-1:0] MAX_W = DATA_W'(POS_MAX);
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] tgt_q;
    logic              tick;
    logic              accept;
    logic [DATA_W:0]   step_res;

    // ------------------------------------------------------------------------
    // Target saturation applied on accept.
    // ------------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] clamp_tgt(input logic [DATA_W-1:0] t);
`ifdef SERVO_RAMP_LIMIT_EN
        if (t < MIN_W)
            return MIN_W;
        else if (t > MAX_W)
            return MAX_W;
        else
            return t;
`else
        return t;
`endif
    endfunction

    // ------------------------------------------------------------------------
    // One frame's move toward dst.
    // MSB of the result flags arrival. The remaining bits are the new position.
    // The difference is taken in DATA_W+1 signed bits, so it cannot overflow.
    // A full step is taken only when |d| > STEP. That condition guarantees
    // that pos +/- STEP stays strictly between pos and dst, so the position
    // can neither wrap nor overshoot.
    // ------------------------------------------------------------------------
    function automatic logic [DATA_W:0] step_toward(input logic [DATA_W-1:0] cur,
                                                    input logic [DATA_W-1:0] dst);
        logic signed [DATA_W:0] d;
        d = $signed({1'b0, dst}) - $signed({1'b0, cur});
        if (d > STEP_S)
            return {1'b0, cur + STEP_W};
        else if (d < -STEP_S)
            return {1'b0, cur - STEP_W};
        else
            return {1'b1, dst};
    endfunction

    // ------------------------------------------------------------------------
    // Frame counter: mirrors the generator's counter, and the tick marks its
    // last cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)
            count <= '0;
        else if (ena)
            count <= (count == CNT_LAST) ? '0 : count + CNT_W'(1);
    end

    assign tick      = ena && (count == CNT_LAST);
    assign tgt_ready = rst_ && (state == IDLE);
    assign accept    = tgt_valid && tgt_ready;
    assign step_res  = step_toward(pos, tgt_q);

    // ------------------------------------------------------------------------
    // Target capture: data only, so no reset is applied here.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept)
            tgt_q <= clamp_tgt(tgt);
    end

    // ------------------------------------------------------------------------
    // Ramp FSM with registered pos/busy/done.
    // A tick that coincides with an accept is ignored, because the FSM is
    // still in IDLE on that edge. The first move therefore lands on the
    // following tick.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state <= IDLE;
            pos   <= INIT_W;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= RAMP;
                        busy  <= 1'b1;
                    end
                end
                RAMP: begin
                    if (tick) begin
                        pos <= step_res[DATA_W-1:0];
                        if (step_res[DATA_W]) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servo_ramp.sv
// ----------------------------------------------------------------------------
// tb_servo_ramp
//
// Self-checking bench for servo_ramp with Tclk=20ns, Tdut=2us (NDUT=100),
// an 8-bit position, STEP=16 and INIT=128.
//
// The reference model plans each ramp as a queue of waypoints when the
// target is accepted. It then pops one waypoint per frame tick. Ticks come
// from a running total of enabled cycles since reset.
// Define SERVO_RAMP_LIMIT_EN to build and check the clamped variant, which
// uses bounds 16..240.
// ----------------------------------------------------------------------------
module tb_servo_ramp;

    localparam int NDUT    = 100;
    localparam int STEP    = 16;
    localparam int INIT    = 128;
    localparam int LIM_MIN = 16;
    localparam int LIM_MAX = 240;

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] tgt = '0;
    logic       tgt_valid = 1'b0;
    logic       tgt_ready;
    logic [7:0] pos;
    logic       busy;
    logic       done;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int m_pos  = INIT;
    int m_en   = 0;
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    int path[$];
    bit mon_on = 1'b0;

    int trace[$];
    int gaps[$];

    always #10 clk = ~clk;

    servo_ramp #(
        .TCLK   (20),
        .TDUT   (2000),
        .DATA_W (8),
        .STEP   (STEP),
        .INIT   (INIT)
`ifdef SERVO_RAMP_LIMIT_EN
        ,
        .POS_MIN(LIM_MIN),
        .POS_MAX(LIM_MAX)
`endif
    ) dut (
        .clk       (clk),
        .rst_      (rst_),
        .ena       (ena),
        .tgt       (tgt),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .pos       (pos),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clamp_t(input int t);
`ifdef SERVO_RAMP_LIMIT_EN
        if (t < LIM_MIN) return LIM_MIN;
        if (t > LIM_MAX) return LIM_MAX;
`endif
        return t;
    endfunction

    // Waypoints from start to dst; a zero-length move still costs one frame.
    task automatic plan(input int start, input int dst);
        int p;
        p = start;
        path.delete();
        do begin
            if (dst - p > STEP)      p = p + STEP;
            else if (p - dst > STEP) p = p - STEP;
            else                     p = dst;
            path.push_back(p);
        end while (p != dst);
    endtask

    task automatic model_reset();
        m_pos  = INIT;
        m_en   = 0;
        m_busy = 1'b0;
        m_done = 1'b0;
        path.delete();
    endtask

    task automatic model_update();
        bit frame_end;
        if (!rst_) begin
            model_reset();
            return;
        end
        frame_end = ena && ((m_en + 1) % NDUT == 0);
        if (ena) m_en++;
        m_done = 1'b0;
        if (m_busy) begin
            if (frame_end) begin
                m_pos = path.pop_front();
                if (path.size() == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else if (tgt_valid) begin
            plan(m_pos, clamp_t(int'(tgt)));
            m_busy = 1'b1;
        end
    endtask

    // One clock: advance the model on the rising edge, then compare on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_update();
        @(negedge clk);
        if (mon_on) begin
            chk("pos",   pos,       m_pos);
            chk("busy",  busy,      m_busy);
            chk("done",  done,      m_done);
            chk("ready", tgt_ready, rst_ && !m_busy);
        end
    endtask

    task automatic accept(input int v);
        tgt       = v[7:0];
        tgt_valid = 1'b1;
        cyc();
        tgt_valid = 1'b0;
        chk("acc_busy", busy, 1);
    endtask

    task automatic async_reset(input string tag);
        #3;
        rst_ = 1'b0;
        model_reset();
        #1;
        chk({tag, "_rst_pos"},   pos,       INIT);
        chk({tag, "_rst_busy"},  busy,      0);
        chk({tag, "_rst_done"},  done,      0);
        chk({tag, "_rst_ready"}, tgt_ready, 0);
        cyc();
        rst_ = 1'b1;
        #1;
        chk({tag, "_rel_ready"}, tgt_ready, 1);
    endtask

    // Record every position change (value and cycles since the previous one)
    // until done is seen or the budget runs out.
    task automatic run_to_done(input string tag, input int budget);
        int prev;
        int last;
        int n;
        trace.delete();
        gaps.delete();
        prev = int'(pos);
        last = 0;
        n    = 0;
        while (n < budget && done !== 1'b1) begin
            cyc();
            n++;
            if (int'(pos) != prev) begin
                trace.push_back(int'(pos));
                gaps.push_back(n - last);
                last = n;
                prev = int'(pos);
            end
        end
        chk({tag, "_done"},       done,      1);
        chk({tag, "_busy_at_dn"}, busy,      0);
        chk({tag, "_ready_at_dn"}, tgt_ready, 1);
        cyc();
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    function automatic int tr(input int i);
        return (i >= 0 && i < trace.size()) ? trace[i] : -1;
    endfunction

    function automatic int gp(input int i);
        return (i >= 0 && i < gaps.size()) ? gaps[i] : -1;
    endfunction

    initial begin
        int e_up[5]   = '{144, 160, 176, 192, 200};
        int e_frz[3]  = '{176, 192, 200};
        int e_dn64[4] = '{112, 96, 80, 64};
        int n;
        int exp_last;
        int exp_prev;

        model_reset();
        repeat (3) cyc();
        chk("init_pos",   pos,       INIT);
        chk("init_busy",  busy,      0);
        chk("init_done",  done,      0);
        chk("init_ready", tgt_ready, 0);

        // Release reset with the enable already high, then ramp upward.
        mon_on = 1'b1;
        ena    = 1'b1;
        rst_   = 1'b1;
        #1;
        chk("rel_ready", tgt_ready, 1);
        accept(200);
        run_to_done("up", 2000);
        chk("up_len", trace.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("up_pos%0d", i), tr(i), e_up[i]);
        chk("up_first_tick", gp(0) + 1, NDUT);
        for (int i = 1; i < 5; i++) chk($sformatf("up_gap%0d", i), gp(i), NDUT);

        // Mid-simulation reset, then a short downward move.
        async_reset("r1");
        accept(120);
        run_to_done("dn", 2000);
        chk("dn_len", trace.size(), 1);
        chk("dn_pos", tr(0), 120);
        chk("dn_first_tick", gp(0) + 1, NDUT);

        // Accept on the tick edge: that tick is skipped.
        n = 0;
        while (((m_en + 1) % NDUT) != 0 && n < 200) begin
            cyc();
            n++;
        end
        chk("tk_align", (m_en + 1) % NDUT, 0);
        accept(110);
        chk("tk_hold", pos, 120);
        run_to_done("tk", 2000);
        chk("tk_len", trace.size(), 1);
        chk("tk_pos", tr(0), 110);
        chk("tk_gap", gp(0), NDUT);

        // Freeze: drop the enable after pos reaches 160.
        async_reset("r2");
        accept(200);
        n = 0;
        while (pos !== 8'd160 && n < 1000) begin
            cyc();
            n++;
        end
        chk("frz_reach", pos, 160);
        ena = 1'b0;
        repeat (250) cyc();
        chk("frz_pos",  pos,  160);
        chk("frz_busy", busy, 1);
        ena = 1'b1;
        run_to_done("frz", 2000);
        chk("frz_len", trace.size(), 3);
        for (int i = 0; i < 3; i++) chk($sformatf("frz_pos%0d", i), tr(i), e_frz[i]);
        chk("frz_resume", gp(0), NDUT);

        // Reset in the middle of a ramp, then a fresh target.
        async_reset("r3");
        accept(200);
        n = 0;
        while (pos !== 8'd176 && n < 1000) begin
            cyc();
            n++;
        end
        chk("mid_reach", pos, 176);
        async_reset("mid");
        accept(64);
        run_to_done("d64", 2000);
        chk("d64_len", trace.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("d64_pos%0d", i), tr(i), e_dn64[i]);

        // Full-scale target: partial last step, clamped in the limited build.
        accept(119);
        run_to_done("p119", 2000);
        chk("p119_pos", pos, 119);
        accept(255);
        run_to_done("lim", 3000);
`ifdef SERVO_RAMP_LIMIT_EN
        exp_last = 240;
        exp_prev = 231;
`else
        exp_last = 255;
        exp_prev = 247;
`endif
        chk("lim_final", pos, exp_last);
        chk("lim_last",  tr(trace.size() - 1), exp_last);
        chk("lim_prev",  tr(trace.size() - 2), exp_prev);

        // Randomized traffic, with enable gaps and one asynchronous reset.
        for (int i = 0; i < 12000; i++) begin
            ena       = ($urandom_range(0, 7) != 0);
            tgt_valid = ($urandom_range(0, 3) == 0);
            tgt       = 8'($urandom);
            cyc();
            if (i == 6000) async_reset("rnd");
        end
        tgt_valid = 1'b0;
        ena       = 1'b1;
        repeat (4) cyc();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/servo_ramp.md
# servo_ramp

Slew-rate limiter that sits directly upstream of the servo PWM generator and drives its `pos` input. It accepts a target position through a valid/ready handshake and moves the output position toward it by at most `STEP` codes per PWM frame. Updates happen only at frame boundaries, so the generator never sees a position change mid-pulse. It runs its own frame counter in lockstep with the generator's counter, using the same clock, reset, enable and period.

## Interface
- `Tclk`, 20ns: clock period; must equal the generator's `Tclk`.
- `Tdut`, 20ms: PWM frame period; must equal the generator's `Tdut`. `Ndut = Tdut / Tclk`.
- `Wpos`, 8: position width.
- `STEP`, 4: maximum position change per frame; legal range 1 .. 2**Wpos-1.
- `INIT`, 2**(Wpos-1): position loaded at reset.
- `POS_MIN`, 0 / `POS_MAX`, 2**Wpos-1: clamp bounds; used only with `SERVO_RAMP_LIMIT_EN`.
- `clk` in 1: clock.
- `rst_` in 1: reset; asynchronous, active-low.
- `ena` in 1: enable; must be the same signal the generator receives.
- `tgt` in Wpos: target position.
- `tgt_valid` in 1: `tgt` is valid.
- `tgt_ready` out 1: block can accept a target.
- `pos` out Wpos: current position; feeds the generator's `pos`.
- `busy` out 1: ramp in progress.
- `done` out 1: one-cycle pulse when `pos` reaches the target.

## Operation
- Frame counter:
  - Width is $clog2(Ndut) bits. Resets to 0.
  - Increments when `ena` is high and wraps from Ndut-1 to 0. Holds when `ena` is low.
  - `tick = ena && count == Ndut-1`.
- FSM states are IDLE and RAMP. Reset enters IDLE.
- IDLE:
  - `tgt_ready = rst_`.
  - Accept occurs when `tgt_valid && tgt_ready`. On accept, latch `tgt` into `tgt_q` and go to RAMP.
  - A target equal to `pos` still goes through RAMP and completes on the next tick.
- RAMP:
  - `tgt_ready = 0`. `busy = 1`.
  - On each tick, compute `d = tgt_q - pos` in Wpos+1 signed bits, so there is no overflow.
  - If |d| <= STEP: `pos <= tgt_q`, `done <= 1`, go to IDLE.
  - Otherwise `pos <= pos + STEP` for d > 0, or `pos <= pos - STEP` for d < 0.
  - `pos` never overshoots `tgt_q` and never wraps.
- `ena` low:
  - No ticks occur, so `pos` is frozen.
  - The handshake still operates: a target can be accepted, and the block then waits in RAMP.
- Reset asserted, at any time including mid-ramp:
  - `pos = INIT`, `busy = 0`, `done = 0`, `tgt_ready = 0`, `count = 0`, state IDLE.
  - The pending target is discarded.

## Timing
- `pos`, `busy` and `done` are registered. `tgt_ready` is combinational from the state register and `rst_`.
- Accept edge to `busy` high: 1 cycle.
- A tick on the same edge as an accept is not used for that target. The first move happens at the next tick.
- `pos` changes only on the tick edge, so the generator sees the new value starting at count 0 of the next frame.
- `done` goes high in the same cycle the final `pos` value first appears, with `busy` low. It lasts exactly 1 cycle.
- `tgt_ready` rises in that same cycle, so a new target can be accepted back-to-back.
- Ramp length in ticks is ceil(|tgt - pos_start| / STEP), minimum 1.
- After reset is released, `tgt_ready = 1` and the first tick comes Ndut cycles after the first enabled cycle.

## Configuration
- Macro: `SERVO_RAMP_LIMIT_EN`.
- Defined: the target is clamped on accept, `tgt_q = min(max(tgt, POS_MIN), POS_MAX)`. `INIT` must lie within the bounds.
- Not defined: `tgt_q = tgt` unchanged, and `POS_MIN`/`POS_MAX` are ignored.

## Test plan
Bench settings: Tclk=20ns, Tdut=2us (Ndut=100), Wpos=8, STEP=16, INIT=128, `ena=1` unless stated.

- Reset: assert `rst_=0` mid-simulation -> `pos=128`, `busy=0`, `done=0`, `tgt_ready=0` immediately. After release, `tgt_ready=1` and `count` restarts at 0.
- Upward ramp: accept `tgt=200` -> `pos` goes 144, 160, 176, 192, 200 on 5 consecutive ticks, 100 cycles apart. `done` pulses 1 cycle with `pos=200`, and `busy` falls in the same cycle.
- Short downward move: from 128, accept `tgt=120` -> `pos=120` on the first tick, `done` pulses, total 1 tick. Also verify accept on the tick edge: the move is delayed to the following tick.
- Freeze: during the ramp to 200, drop `ena` for 250 cycles after `pos=160` -> `pos` holds 160 and `count` holds. After `ena` returns, the ramp resumes and reaches 200 three ticks later.
- Reset mid-ramp: assert `rst_` while `pos=176` -> `pos=128`, state IDLE. A new `tgt=64` is then accepted normally and reaches `pos=64` after 4 ticks.
- Limit: with `SERVO_RAMP_LIMIT_EN` defined, `POS_MIN=16`, `POS_MAX=240`, `tgt=255` -> final `pos=240`. Without the macro -> final `pos=255` and no wrap on the last step (partial step 247 -> 255).
